input_event_player: RTL and testbench

INPUT_EVENT_PLAYER -- requirements
Module: input_event_player

---
 rtl/input_event_player_pkg.sv | 7 +
 rtl/event_fifo.sv | 35 +++
 rtl/input_event_player.sv | 55 +++++
 tb/tb_input_event_player.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/input_event_player_pkg.sv
// input_event_player_pkg: shared FSM state encoding and default sizes.
package input_event_player_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_t;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF = 8;
  localparam int DELAY_W_DEF = 32;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: power-of-two queue of {delay, value} events with occupancy count.
module event_fifo import input_event_player_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = DELAY_W_DEF + DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk) if (push) mem[wptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  assign dout = mem[rptr];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/input_event_player.sv
// input_event_player: replays queued events as one-cycle strobes after per-event delays.
module input_event_player import input_event_player_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         evt_valid,
  input  logic [DELAY_W-1:0]           evt_delay,
  input  logic signed [DATA_W-1:0]     evt_value,
  output logic                         evt_ready,
  output logic signed [DATA_W-1:0]     input_0,
  output logic                         new_input_0,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int W = DELAY_W + DATA_W;
  state_t state;
  logic [DELAY_W-1:0] cnt;
  logic live, full, empty, fire;
  logic [W-1:0] head;
  assign fire = state == WAIT && en && cnt == '0;
  // live keeps evt_ready low until the first edge after reset release
  assign evt_ready = live && !full;
  assign busy = !empty || state != IDLE;
  event_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .push(evt_valid && evt_ready), .pop(fire),
    .din({evt_delay, evt_value}), .dout(head), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      live <= 1'b0;
      new_input_0 <= 1'b0;
      input_0 <= '0;
    end else begin
      live <= 1'b1;
      new_input_0 <= fire;
      input_0 <= fire ? head[DATA_W-1:0] : '0;
      case (state)
        IDLE: if (!empty) begin
          state <= WAIT;
          cnt <= head[W-1:DATA_W];
        end
        WAIT: if (en) begin
          if (cnt == '0) state <= FIRE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_input_event_player.sv
// tb_input_event_player: directed + random bench with an edge-counting event schedule model.
module tb_input_event_player;
  localparam int DP = 8;
  logic clk = 0, rst = 1, en = 0, evt_valid = 0;
  logic [31:0] evt_delay = 0;
  logic signed [63:0] evt_value = 0;
  logic evt_ready, new_input_0, busy;
  logic signed [63:0] input_0;
  logic [3:0] level;

  input_event_player #(.DATA_W(64), .DEPTH(DP), .DELAY_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .evt_valid(evt_valid), .evt_delay(evt_delay),
    .evt_value(evt_value), .evt_ready(evt_ready), .input_0(input_0),
    .new_input_0(new_input_0), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int a; int d; logic signed [63:0] v;} ev_t;
  ev_t q[$];
  int hs = 0, en_cnt = 0, last_fire = -100, n = 0;
  bit alive = 0, acc = 0, m_new = 0;
  logic signed [63:0] m_val = 0;
  int obs_t[$];
  logic signed [63:0] obs_v[$];

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each event starts its countdown one edge after acceptance, or two edges after the
  // previous strobe, and fires on its (delay+1)-th enabled edge after that start.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      alive = 0; acc = 0; m_new = 0; m_val = 0; en_cnt = 0; last_fire = -100;
    end else begin
      n = cyc + 1;
      acc = evt_valid && alive && q.size() != DP;
      alive = 1; m_new = 0; m_val = 0;
      if (q.size() != 0 && n > hs) begin
        if (en) en_cnt++;
        if (en_cnt == q[0].d + 1) begin
          m_new = 1; m_val = q[0].v; last_fire = n;
          void'(q.pop_front());
          if (q.size() != 0) begin
            hs = (q[0].a + 1 > n + 2) ? q[0].a + 1 : n + 2;
            en_cnt = 0;
          end
        end
      end
      if (acc) begin
        q.push_back('{n, int'(evt_delay), evt_value});
        if (q.size() == 1) begin
          hs = (n + 1 > last_fire + 2) ? n + 1 : last_fire + 2;
          en_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("evt_ready", evt_ready, alive && q.size() != DP);
    chk("level", level, q.size());
    chk("busy", busy, q.size() != 0 || m_new);
    chk("new_input_0", new_input_0, m_new);
    chk("input_0", input_0, m_val);
    if (new_input_0 === 1'b1) begin
      obs_t.push_back(cyc);
      obs_v.push_back(input_0);
    end
  end

  task automatic push(int d, logic signed [63:0] v, output int k);
    evt_delay = d; evt_value = v; evt_valid = 1; k = -1;
    for (int i = 0; i < 3000 && k < 0; i++) begin
      @(posedge clk); #1;
      if (acc) k = cyc;
    end
    if (k < 0) chk("push_timeout", 0, 1);
    @(negedge clk);
    evt_valid = 0;
  endtask

  task automatic wait_idle(int lim);
    int i = 0;
    while (busy !== 1'b0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (i >= lim) chk("idle_timeout", busy, 0);
  endtask

  task automatic clear_obs();
    obs_t.delete();
    obs_v.delete();
  endtask

  int k, k1, k2, k5;
  int kk[9];

  initial begin
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", evt_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    rst = 1; en = 1;
    @(posedge clk); #1;
    chk("ready_after_release", evt_ready, 1);
    @(negedge clk);

    clear_obs();
    push(5, 1, k);
    wait_idle(200);
    chk("single_count", obs_t.size(), 1);
    chk("single_time", obs_t.size() > 0 ? obs_t[0] : -1, k + 7);
    chk("single_value", obs_v.size() > 0 ? obs_v[0] : 0, 1);
    chk("single_busy_after", busy, 0);

    clear_obs();
    push(0, -3, k1);
    push(2, 25, k2);
    wait_idle(200);
    chk("pair_consecutive", k2 - k1, 1);
    chk("pair_count", obs_t.size(), 2);
    chk("pair_first_time", obs_t.size() > 0 ? obs_t[0] : -1, k1 + 2);
    chk("pair_v0", obs_v.size() > 0 ? obs_v[0] : 0, -3);
    chk("pair_v1", obs_v.size() > 1 ? obs_v[1] : 0, 25);
    chk("pair_spacing", obs_t.size() > 1 ? obs_t[1] - obs_t[0] : -1, 5);

    clear_obs();
    for (int i = 0; i < 9; i++) begin
      push(100, 64'(i + 10), kk[i]);
      if (i == 7) begin
        chk("full_level", level, 8);
        chk("full_ready", evt_ready, 0);
      end
    end
    chk("ninth_after_pop", kk[8], obs_t.size() > 0 ? obs_t[0] + 1 : -1);
    wait_idle(3000);
    chk("nine_count", obs_t.size(), 9);
    for (int i = 0; i < 9; i++)
      chk("nine_order", obs_v.size() > i ? obs_v[i] : 0, 64'(i + 10));

    clear_obs();
    push(10, 7, k);
    while (cyc < k + 4) @(negedge clk);
    en = 0;
    repeat (4) @(negedge clk);
    en = 1;
    wait_idle(200);
    chk("stall_time", obs_t.size() > 0 ? obs_t[0] : -1, k + 16);

    clear_obs();
    for (int i = 0; i < 3; i++) push(20, 64'(i + 100), k);
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("midreset_level", level, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", evt_ready, 0);
    chk("midreset_strobe", new_input_0, 0);
    chk("midreset_model_level", q.size(), 0);
    @(negedge clk);
    rst = 1;
    repeat (50) @(negedge clk);
    chk("midreset_no_strobe", obs_t.size(), 0);

    clear_obs();
    push(4, 1, k1);
    for (int i = 0; i < 3; i++) push(4, 64'(i + 2), k);
    while (cyc < k1 + 5) @(negedge clk);
    push(9, 55, k5);
    chk("pushpop_edge", k5, k1 + 6);
    chk("pushpop_level", level, 4);
    chk("pushpop_ready", evt_ready, 1);
    chk("pushpop_model_level", q.size(), 4);
    wait_idle(500);
    chk("pushpop_count", obs_t.size(), 5);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      evt_valid = ($urandom % 3) == 0;
      evt_delay = $urandom % 7;
      evt_value = {$urandom, $urandom};
      en = ($urandom % 6) != 0;
      if ($urandom % 600 == 0) begin
        #2 rst = 0;
        @(negedge clk);
        rst = 1;
      end
    end
    @(negedge clk);
    evt_valid = 0; en = 1;
    wait_idle(2000);
    chk("final_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
